score_update_ctrl: RTL and testbench
====================================

// Module: score_update_ctrl
// PURPOSE
//  Owns the game score register and sequences every change to it. Arbitrates
//  add requests from two sources (A and B) and saturates the score at MAX_SCORE.
//  Converts each new score to four BCD digits with a 16-step shift-add-3
//  sequence, so the display path needs no combinational dividers.
//  Sits between the game FSM / event sources and the 7-seg decoders.
// PARAMETERS
//  MAX_SCORE  9999  saturation ceiling; must be <= 9999 so 4 BCD digits suffice
//  INC_W      8     width of each add amount
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  clear         in   1      synchronous score clear, highest priority
//  req_a         in   1      requester A add request; held high until granted
//  amt_a         in   INC_W  requester A add amount; stable while req_a is high
//  req_b         in   1      requester B add request; held high until granted
//  amt_b         in   INC_W  requester B add amount; stable while req_b is high
//  gnt_a         out  1      1-cycle accept pulse for A
//  gnt_b         out  1      1-cycle accept pulse for B
//  score         out  16     binary score, 0..MAX_SCORE
//  bcd_th        out  4      thousands digit
//  bcd_hu        out  4      hundreds digit
//  bcd_te        out  4      tens digit
//  bcd_on        out  4      ones digit
//  digits_valid  out  1      BCD outputs match score
//  busy          out  1      conversion in progress
//  overflow      out  1      sticky flag: an add was clipped at MAX_SCORE
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - score=0, all bcd_*=0, digits_valid=1, busy=0, gnt_*=0, overflow=0.
//   - state=IDLE, round-robin pointer favours A.
//  FSM states: IDLE and CONV.
//  IDLE:
//   - gnt_* is Mealy: decoded combinationally from IDLE & req & !clear.
//   - Only A requesting: grant A. Only B requesting: grant B.
//   - Both requesting: grant the one not granted last.
//   - On the grant edge: score <= min(score+amt, MAX_SCORE), computed 17-bit.
//   - If the sum exceeds MAX_SCORE, set overflow (sticky).
//   - Also on the grant edge: load the shift register with the new score,
//     step count=0, digits_valid=0, busy=1, state -> CONV.
//   - An amt=0 request is still granted and still converted.
//  CONV:
//   - One double-dabble step per cycle: add 3 to any BCD nibble >= 5,
//     then shift left 1.
//   - On the 16th step edge: latch bcd_*, digits_valid=1, busy=0,
//     state -> IDLE.
//   - No grants in CONV; pending requests wait.
//   - Latency: grant in cycle 0; digits_valid high from cycle 17.
//   - Old bcd_* values are held during CONV.
//  clear=1 (any state):
//   - Next edge: score=0, bcd_*=0, digits_valid=1, busy=0, overflow=0,
//     state=IDLE.
//   - Aborts any conversion in progress. No grant while clear=1.
//   - The round-robin pointer is unchanged.
//  At most one grant per conversion; back-to-back grants are 17 cycles apart.
// TESTING
//  1. Reset: all outputs at the reset values above; digits 0000, digits_valid=1.
//  2. From 0, req_a with amt_a=5:
//     - gnt_a high for exactly 1 cycle; score=5 after the next edge.
//     - busy high for 16 cycles; digits 0,0,0,5 with valid in cycle 17.
//  3. From 0, req_a (amt_a=10) and req_b (amt_b=20) raised together:
//     - gnt_a first, then gnt_b 17 cycles later.
//     - Final score=30, digits 0030, overflow=0.
//  4. Score=9990, req_b with amt_b=25:
//     - score=9999, overflow=1, digits 9999.
//     - A following amt_b=0 keeps overflow=1.
//  5. clear in cycle 8 of CONV while req_b is held:
//     - Next edge: score=0, digits 0000, valid=1, busy=0.
//     - gnt_b follows in the next IDLE cycle.
//  6. Alternate A/B adds summing to 1234:
//     - Grants alternate A,B,A,...; final digits 1,2,3,4; score=16'd1234.

Source files
------------

// File: rtl/score_update_ctrl.sv
// Score register with round-robin add arbitration, saturation at MAX_SCORE,
// and a sequential 16-step double-dabble conversion to four BCD digits.
module score_update_ctrl #(
    parameter int MAX_SCORE = 9999,
    parameter int INC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             req_a,
    input  logic [INC_W-1:0] amt_a,
    input  logic             req_b,
    input  logic [INC_W-1:0] amt_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [15:0]      score,
    output logic [3:0]       bcd_th,
    output logic [3:0]       bcd_hu,
    output logic [3:0]       bcd_te,
    output logic [3:0]       bcd_on,
    output logic             digits_valid,
    output logic             busy,
    output logic             overflow
);

    localparam logic [0:0]  IDLE    = 1'b0;
    localparam logic [0:0]  CONV    = 1'b1;
    localparam logic [16:0] MAX_EXT = 17'(MAX_SCORE);

    logic [0:0]       state_reg;
    logic             prefer_b_reg;
    logic [15:0]      score_reg;
    logic [31:0]      dd_reg;
    logic [3:0]       step_reg;
    logic [15:0]      bcd_reg;
    logic             valid_reg;
    logic             overflow_reg;

    logic             grant_ok;
    logic [INC_W-1:0] amt_sel;
    logic [16:0]      sum_ext;
    logic             clipped;
    logic [15:0]      new_score;
    logic [31:0]      dd_adj;
    logic [31:0]      dd_shift;

    // Grants are Mealy so the requester sees acceptance in the same cycle.
    assign grant_ok = (state_reg == IDLE) && !clear;
    assign gnt_a    = grant_ok && req_a && (!req_b || !prefer_b_reg);
    assign gnt_b    = grant_ok && req_b && (!req_a || prefer_b_reg);

    assign amt_sel   = gnt_a ? amt_a : amt_b;
    assign sum_ext   = {1'b0, score_reg} + 17'(amt_sel);
    assign clipped   = sum_ext > MAX_EXT;
    assign new_score = clipped ? MAX_EXT[15:0] : sum_ext[15:0];

    // Upper 16 bits are the BCD accumulator, lower 16 the binary being shifted in.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign dd_adj[16+4*gi +: 4] = (dd_reg[16+4*gi +: 4] >= 4'd5)
                                        ? dd_reg[16+4*gi +: 4] + 4'd3
                                        : dd_reg[16+4*gi +: 4];
        end
    endgenerate
    assign dd_adj[15:0] = dd_reg[15:0];
    // Rotate rather than shift: the wrapped bit is always zero for scores <= 9999
    // and never reaches the BCD half within 16 steps.
    assign dd_shift = {dd_adj[30:0], dd_adj[31]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prefer_b_reg <= 1'b0;
            score_reg    <= 16'd0;
            dd_reg       <= 32'd0;
            step_reg     <= 4'd0;
            bcd_reg      <= 16'd0;
            valid_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            state_reg    <= IDLE;
            score_reg    <= 16'd0;
            bcd_reg      <= 16'd0;
            valid_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_a || gnt_b) begin
                        score_reg    <= new_score;
                        if (clipped) overflow_reg <= 1'b1;
                        dd_reg       <= {16'd0, new_score};
                        step_reg     <= 4'd0;
                        valid_reg    <= 1'b0;
                        prefer_b_reg <= gnt_a;
                        state_reg    <= CONV;
                    end
                end
                CONV: begin
                    dd_reg   <= dd_shift;
                    step_reg <= step_reg + 4'd1;
                    if (step_reg == 4'd15) begin
                        bcd_reg   <= dd_shift[31:16];
                        valid_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign score        = score_reg;
    assign bcd_th       = bcd_reg[15:12];
    assign bcd_hu       = bcd_reg[11:8];
    assign bcd_te       = bcd_reg[7:4];
    assign bcd_on       = bcd_reg[3:0];
    assign digits_valid = valid_reg;
    assign busy         = (state_reg == CONV);
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_score_update_ctrl.sv
// Bench for score_update_ctrl: directed scenarios plus random add traffic,
// checked against an arithmetic score/arbitration model.
module tb_score_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req_a, req_b;
    logic [7:0]  amt_a, amt_b;
    logic        gnt_a, gnt_b;
    logic [15:0] score;
    logic [3:0]  bcd_th, bcd_hu, bcd_te, bcd_on;
    logic        digits_valid, busy, overflow;

    int total = 0;
    int bad   = 0;

    int model_score = 0;
    bit model_ovf   = 1'b0;
    bit last_b      = 1'b1;   // after reset the arbiter favours A

    score_update_ctrl #(.MAX_SCORE(9999), .INC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req_a(req_a), .amt_a(amt_a), .req_b(req_b), .amt_b(amt_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .score(score),
        .bcd_th(bcd_th), .bcd_hu(bcd_hu), .bcd_te(bcd_te), .bcd_on(bcd_on),
        .digits_valid(digits_valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_settled(input string tag);
        chk({tag, ":score"}, int'(score), model_score);
        chk({tag, ":th"}, int'(bcd_th), model_score / 1000);
        chk({tag, ":hu"}, int'(bcd_hu), (model_score / 100) % 10);
        chk({tag, ":te"}, int'(bcd_te), (model_score / 10) % 10);
        chk({tag, ":on"}, int'(bcd_on), model_score % 10);
        chk({tag, ":valid"}, int'(digits_valid), 1);
        chk({tag, ":busy"}, int'(busy), 0);
        chk({tag, ":ovf"}, int'(overflow), int'(model_ovf));
    endtask

    function automatic void model_add(input int amt);
        if (model_score + amt > 9999) begin
            model_score = 9999;
            model_ovf   = 1'b1;
        end else begin
            model_score = model_score + amt;
        end
    endfunction

    // Called at the grant cycle; follows the conversion until digits are valid.
    task automatic wait_conv(input bit was_a);
        bit stray = 1'b0;
        int n;
        step();
        if (was_a) req_a = 1'b0; else req_b = 1'b0;
        chk("busy_c1", int'(busy), 1);
        chk("valid_c1", int'(digits_valid), 0);
        chk("score_c1", int'(score), model_score);
        n = 1;
        while (!digits_valid && n < 40) begin
            if (gnt_a || gnt_b) stray = 1'b1;
            step();
            n++;
        end
        chk("latency", n, 17);
        chk("stray_gnt", int'(stray), 0);
        check_settled("conv");
        $display("add done: score=%0d digits=%0d%0d%0d%0d ovf=%0d",
                 score, bcd_th, bcd_hu, bcd_te, bcd_on, overflow);
    endtask

    task automatic grant_one();
        bit exp_a;
        #1;
        exp_a = req_a && (!req_b || last_b);
        chk("gnt_a", int'(gnt_a), int'(exp_a));
        chk("gnt_b", int'(gnt_b), int'(!exp_a));
        model_add(exp_a ? int'(amt_a) : int'(amt_b));
        last_b = !exp_a;
        wait_conv(exp_a);
    endtask

    task automatic run_reqs(input bit ra, input int aa, input bit rb, input int ab);
        req_a = ra; amt_a = 8'(aa);
        req_b = rb; amt_b = 8'(ab);
        while (req_a || req_b) grant_one();
    endtask

    task automatic clear_score();
        req_a = 1'b1; amt_a = 8'd1;
        clear = 1'b1;
        #1;
        chk("gnt_during_clear", int'(gnt_a), 0);
        step();
        clear = 1'b0;
        req_a = 1'b0;
        model_score = 0;
        model_ovf   = 1'b0;
        check_settled("clear");
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        req_a = 1'b0; req_b = 1'b0; amt_a = 8'd0; amt_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_settled("reset");
        chk("reset:gnt_a", int'(gnt_a), 0);
        chk("reset:gnt_b", int'(gnt_b), 0);
        rst_n = 1'b1;
        step();

        // Simultaneous requests from reset: A first, then B.
        run_reqs(1'b1, 10, 1'b1, 20);
        chk("t3:score", int'(score), 30);
        chk("t3:ovf", int'(overflow), 0);

        clear_score();
        run_reqs(1'b1, 5, 1'b0, 0);
        chk("t2:score", int'(score), 5);
        chk("t2:on", int'(bcd_on), 5);

        // Saturation.
        clear_score();
        repeat (39) run_reqs(1'b1, 255, 1'b0, 0);
        run_reqs(1'b0, 0, 1'b1, 45);
        chk("t4:pre", int'(score), 9990);
        run_reqs(1'b0, 0, 1'b1, 25);
        chk("t4:score", int'(score), 9999);
        chk("t4:ovf", int'(overflow), 1);
        chk("t4:th", int'(bcd_th), 9);
        run_reqs(1'b0, 0, 1'b1, 0);
        chk("t4:ovf_sticky", int'(overflow), 1);

        // Clear aborting a conversion while B keeps requesting.
        req_a = 1'b0; req_b = 1'b1; amt_b = 8'd7;
        #1;
        chk("t5:gnt_b", int'(gnt_b), 1);
        model_add(7);
        last_b = 1'b1;
        repeat (8) step();
        clear = 1'b1;
        #1;
        chk("t5:gnt_in_clear", int'(gnt_b), 0);
        step();
        clear = 1'b0;
        model_score = 0;
        model_ovf   = 1'b0;
        check_settled("t5");
        #1;
        chk("t5:gnt_b_after", int'(gnt_b), 1);
        chk("t5:gnt_a_after", int'(gnt_a), 0);
        model_add(7);
        wait_conv(1'b0);

        // Alternating adds reaching 1234.
        clear_score();
        repeat (6) run_reqs(1'b1, 100, 1'b1, 100);
        run_reqs(1'b1, 17, 1'b1, 17);
        chk("t6:score", int'(score), 1234);
        chk("t6:th", int'(bcd_th), 1);
        chk("t6:hu", int'(bcd_hu), 2);
        chk("t6:te", int'(bcd_te), 3);
        chk("t6:on", int'(bcd_on), 4);

        // Random traffic.
        repeat (30) begin
            int pat;
            if ($urandom_range(0, 7) == 0) clear_score();
            pat = int'($urandom_range(1, 3));
            run_reqs(pat[0], int'($urandom_range(0, 255)),
                     pat[1], int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
